// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: steers one input stream of {data, reg} beats to one of two output ports.
// Each port owns an independent 2-entry FIFO, so a stalled consumer on one port never blocks
// beats bound for the other port.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ready reflects only the selected port's fullness
//   in_sel                 destination: 0 -> port 0 (AR-type), 1 -> port 1 (T-type)
//   in_data/in_reg         beat payload, stored unmodified
//   outN_valid/outN_ready  per-port output handshake
//   outN_data/outN_reg     per-port FIFO head, read straight from storage flops
//   cnt0/cnt1              per-port occupancy (0..2)
module demux_1to2_buf #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sel,
  input  logic [DW-1:0] in_data,
  input  logic [RW-1:0] in_reg,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out0_data,
  output logic [RW-1:0] out0_reg,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [DW-1:0] out1_data,
  output logic [RW-1:0] out1_reg,
  output logic [1:0]    cnt0,
  output logic [1:0]    cnt1
);

  // Storage indexed [port][slot].
  logic [1:0][1:0][DW-1:0] data_q, data_d;
  logic [1:0][1:0][RW-1:0] reg_q, reg_d;
  logic [1:0]              wr_ptr_q, wr_ptr_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic [1:0][1:0]         cnt_q, cnt_d;

  logic [1:0] push, pop, out_valid, out_ready;

  // Readiness depends only on the selected port's registered count, never on the consumers,
  // so a full port cannot accept even if it is being drained this cycle.
  assign in_ready  = in_sel ? (cnt_q[1] != 2'd2) : (cnt_q[0] != 2'd2);

  assign out_ready = {out1_ready, out0_ready};
  assign out_valid = {(cnt_q[1] != 2'd0), (cnt_q[0] != 2'd0)};

  assign push = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
  assign pop  = out_valid & out_ready;

  always_comb begin
    data_d   = data_q;
    reg_d    = reg_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        data_d[p][wr_ptr_q[p]] = in_data;
        reg_d[p][wr_ptr_q[p]]  = in_reg;
        wr_ptr_d[p]            = ~wr_ptr_q[p];
      end
      if (pop[p]) begin
        rd_ptr_d[p] = ~rd_ptr_q[p];
      end
      // Push into a full port is blocked by in_ready, so the count stays within 0..2.
      unique case ({push[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + 2'd1;
        2'b01:   cnt_d[p] = cnt_q[p] - 2'd1;
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  // Storage is cleared too so the heads read 0 after reset until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      reg_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      reg_q    <= reg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out0_valid = out_valid[0];
  assign out1_valid = out_valid[1];
  assign out0_data  = data_q[0][rd_ptr_q[0]];
  assign out0_reg   = reg_q[0][rd_ptr_q[0]];
  assign out1_data  = data_q[1][rd_ptr_q[1]];
  assign out1_reg   = reg_q[1][rd_ptr_q[1]];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Bench for demux_1to2_buf: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against two reference queues (one per port).
module tb_demux_1to2_buf;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sel = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] in_reg = '0;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b0;
  logic          out1_ready = 1'b0;
  logic [DW-1:0] out0_data, out1_data;
  logic [RW-1:0] out0_reg, out1_reg;
  logic [1:0]    cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  demux_1to2_buf #(.DW(DW), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_reg     (in_reg),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_reg   (out0_reg),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_reg   (out1_reg),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue of {data, reg} per port plus "pushed since reset" flags.
  logic [DW+RW-1:0] q0[$];
  logic [DW+RW-1:0] q1[$];
  bit seen0 = 1'b0;
  bit seen1 = 1'b0;
  bit m_pop0, m_pop1, m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      seen0 = 1'b0;
      seen1 = 1'b0;
    end else begin
      m_pop0 = out0_ready && (q0.size() > 0);
      m_pop1 = out1_ready && (q1.size() > 0);
      m_rdy  = in_sel ? (q1.size() < 2) : (q0.size() < 2);
      if (m_pop0) void'(q0.pop_front());
      if (m_pop1) void'(q1.pop_front());
      if (in_valid && m_rdy) begin
        if (in_sel) begin
          q1.push_back({in_data, in_reg});
          seen1 = 1'b1;
        end else begin
          q0.push_back({in_data, in_reg});
          seen0 = 1'b1;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT outputs versus model.
  always @(negedge clk) begin
    chk("cnt0", 64'(cnt0), 64'(q0.size()));
    chk("cnt1", 64'(cnt1), 64'(q1.size()));
    chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
    chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(in_sel ? (q1.size() < 2) : (q0.size() < 2)));
    if (q0.size() != 0) begin
      chk("out0_data", 64'(out0_data), 64'(q0[0][DW+RW-1:RW]));
      chk("out0_reg", 64'(out0_reg), 64'(q0[0][RW-1:0]));
    end else if (!seen0) begin
      chk("out0_data_rst", 64'({out0_data, out0_reg}), 64'd0);
    end
    if (q1.size() != 0) begin
      chk("out1_data", 64'(out1_data), 64'(q1[0][DW+RW-1:RW]));
      chk("out1_reg", 64'(out1_reg), 64'(q1[0][RW-1:0]));
    end else if (!seen1) begin
      chk("out1_data_rst", 64'({out1_data, out1_reg}), 64'd0);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d,
                       input logic [RW-1:0] r);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_reg   = r;
  endtask

  initial begin
    // Reset state.
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_out0_data", 64'(out0_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single beat to port 0 appears after one edge.
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 4'h5);
    edge1();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("t1_out0_valid", 64'(out0_valid), 64'd1);
    chk("t1_out0_data", 64'(out0_data), 64'hDEAD_BEEF);
    chk("t1_out0_reg", 64'(out0_reg), 64'h5);
    chk("t1_cnt0", 64'(cnt0), 64'd1);
    chk("t1_out1_valid", 64'(out1_valid), 64'd0);

    // Fill port 1 with A, B; C is held off while full.
    drive(1'b1, 1'b1, 32'hAAAA_0001, 4'h1);
    edge1();
    drive(1'b1, 1'b1, 32'hBBBB_0002, 4'h2);
    edge1();
    drive(1'b1, 1'b1, 32'hCCCC_0003, 4'h3);
    #1;
    chk("t2_cnt1", 64'(cnt1), 64'd2);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    edge1();
    chk("t2_cnt1_held", 64'(cnt1), 64'd2);
    chk("t2_head_a", 64'(out1_data), 64'hAAAA_0001);

    // Port 1 full does not block port 0.
    drive(1'b1, 1'b0, 32'h7777_0007, 4'h7);
    #1;
    chk("t3_in_ready_p0", 64'(in_ready), 64'd1);
    edge1();
    chk("t3_cnt0", 64'(cnt0), 64'd2);
    chk("t3_cnt1", 64'(cnt1), 64'd2);
    chk("t3_head_a", 64'(out1_data), 64'hAAAA_0001);

    // Drain port 1 while C waits for space: order A, B, C.
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 32'hCCCC_0003, 4'h3);
    edge1();
    chk("t4_head_b", 64'(out1_data), 64'hBBBB_0002);
    chk("t4_cnt1", 64'(cnt1), 64'd1);
    edge1();
    drive(1'b0, 1'b1, '0, '0);
    chk("t4_head_c", 64'(out1_data), 64'hCCCC_0003);
    chk("t4_cnt1_pp", 64'(cnt1), 64'd1);
    edge1();
    chk("t4_out1_empty", 64'(out1_valid), 64'd0);
    out1_ready = 1'b0;

    // Port 0: pop DEADBEEF, then simultaneous push X / pop Y.
    out0_ready = 1'b1;
    edge1();
    chk("t5_cnt0", 64'(cnt0), 64'd1);
    chk("t5_head_y", 64'(out0_data), 64'h7777_0007);
    drive(1'b1, 1'b0, 32'h1234_5678, 4'h9);
    edge1();
    chk("t5_cnt0_pp", 64'(cnt0), 64'd1);
    chk("t5_head_x", 64'(out0_data), 64'h1234_5678);
    chk("t5_reg_x", 64'(out0_reg), 64'h9);
    out0_ready = 1'b0;

    // cnt0=2, cnt1=1, then asynchronous reset between edges.
    drive(1'b1, 1'b0, 32'h0BAD_F00D, 4'hA);
    edge1();
    drive(1'b1, 1'b1, 32'h5555_AAAA, 4'hB);
    edge1();
    drive(1'b0, 1'b0, '0, '0);
    chk("t6_cnt0", 64'(cnt0), 64'd2);
    chk("t6_cnt1", 64'(cnt1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_v0", 64'(out0_valid), 64'd0);
    chk("t6_rst_v1", 64'(out1_valid), 64'd0);
    chk("t6_rst_cnt", 64'({cnt0, cnt1}), 64'd0);
    chk("t6_rst_data", 64'({out0_data, out1_data}), 64'd0);
    chk("t6_rst_reg", 64'({out0_reg, out1_reg}), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    edge1();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'hFEED_0042, 4'hC);
    edge1();
    drive(1'b0, 1'b0, '0, '0);
    chk("t6_after_v1", 64'(out1_valid), 64'd1);
    chk("t6_after_d1", 64'(out1_data), 64'hFEED_0042);
    chk("t6_after_cnt1", 64'(cnt1), 64'd1);
    chk("t6_after_cnt0", 64'(cnt0), 64'd0);

    // Randomized traffic, checked by the compare process each cycle.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, 4'($urandom_range(0, 15)));
      out0_ready = 1'($urandom_range(0, 2) == 0);
      out1_ready = 1'($urandom_range(0, 1));
      edge1();
    end
    drive(1'b0, 1'b0, '0, '0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (4) edge1();
    chk("end_drained", 64'({cnt0, cnt1}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
